// File: rtl/ariane_pkg.sv
// Shared writeback types for the execute stage.
// Default widths match the 64-bit core configuration.
package ariane_pkg;

    localparam int unsigned XLEN_W        = 64;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned NR_WB_PORTS   = 2;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN_W-1:0]        result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t               exception;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-unit result FIFO: registered full/empty, no read-through bypass.
// Depth must be a power of two (1 allowed).
module wb_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned Depth   = 2,
    parameter type         entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  entry_t data,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    entry_t            mem [Depth];
    logic [PtrW-1:0]   rd_ptr;
    logic [PtrW-1:0]   wr_ptr;
    logic [CntW-1:0]   cnt;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CntW'(Depth));
    assign empty   = (cnt == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; the count alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/flu_wb_arbiter.sv
// Round-robin writeback arbiter: NrFu buffered result streams onto NrWbPorts.
// Optional FLU_WB_PERF_EN adds a saturating port-conflict counter.
module flu_wb_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NrFu        = 4,
    parameter int unsigned NrWbPorts   = NR_WB_PORTS,
    parameter int unsigned Depth       = 2,
    parameter int unsigned XLEN        = XLEN_W,
    parameter int unsigned TransIdBits = TRANS_ID_BITS
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   flush_i,
    input  logic [NrFu-1:0]                        fu_valid_i,
    output logic [NrFu-1:0]                        fu_ready_o,
    input  logic [NrFu-1:0][XLEN-1:0]              fu_result_i,
    input  logic [NrFu-1:0][TransIdBits-1:0]       fu_trans_id_i,
    input  exception_t [NrFu-1:0]                  fu_exception_i,
    output logic [NrWbPorts-1:0]                   wb_valid_o,
    output logic [NrWbPorts-1:0][XLEN-1:0]         wb_result_o,
    output logic [NrWbPorts-1:0][TransIdBits-1:0]  wb_trans_id_o,
    output exception_t [NrWbPorts-1:0]             wb_exception_o
`ifdef FLU_WB_PERF_EN
    ,
    output logic [31:0]                            conflict_cnt_o
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]        result;
        logic [TransIdBits-1:0] trans_id;
        exception_t             exception;
    } entry_t;

    localparam int unsigned RrW = (NrFu > 1) ? $clog2(NrFu) : 1;

    logic [NrFu-1:0] full;
    logic [NrFu-1:0] empty;
    logic [NrFu-1:0] pop;
    entry_t          head [NrFu];
    entry_t          din  [NrFu];
    logic [RrW-1:0]  rr_q;
    logic [RrW-1:0]  rr_d;

    for (genvar i = 0; i < NrFu; i++) begin : g_fifo
        assign din[i] = '{
            result:    fu_result_i[i],
            trans_id:  fu_trans_id_i[i],
            exception: fu_exception_i[i]
        };

        wb_fifo #(
            .Depth   (Depth),
            .entry_t (entry_t)
        ) u_fifo (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .flush (flush_i),
            .push  (fu_valid_i[i]),
            .pop   (pop[i]),
            .data  (din[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    assign fu_ready_o = ~full;

    // Walk units from rr_q upward; the k-th nonempty head lands on port k.
    always_comb begin
        int unsigned k;
        int unsigned idx;
        k              = 0;
        idx            = 0;
        pop            = '0;
        rr_d           = rr_q;
        wb_valid_o     = '0;
        wb_result_o    = '0;
        wb_trans_id_o  = '0;
        wb_exception_o = '0;
        for (int unsigned j = 0; j < NrFu; j++) begin
            idx = (int'(rr_q) + j) % NrFu;
            if (!empty[idx] && k < NrWbPorts) begin
                pop[idx]          = 1'b1;
                wb_valid_o[k]     = 1'b1;
                wb_result_o[k]    = head[idx].result;
                wb_trans_id_o[k]  = head[idx].trans_id;
                wb_exception_o[k] = head[idx].exception;
                rr_d              = RrW'((idx + 1) % NrFu);
                k++;
            end
        end
    end

    // Writes shown during a flush are discarded, so they do not move the pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (!flush_i) begin
            rr_q <= rr_d;
        end
    end

`ifdef FLU_WB_PERF_EN
    logic [31:0] conflict_q;

    always_ff @(posedge clk_i) begin
        int unsigned ne;
        ne = 0;
        for (int unsigned i = 0; i < NrFu; i++) begin
            if (!empty[i]) ne++;
        end
        if (!rst_ni) begin
            conflict_q <= '0;
        end else if (ne > NrWbPorts && conflict_q != '1) begin
            conflict_q <= conflict_q + 1'b1;
        end
    end

    assign conflict_cnt_o = conflict_q;
`endif

endmodule
